// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory-sequencer state encoding and default wait-state timeout.
package cpu_defs;

    typedef logic [2:0] mem_state_t;

    localparam mem_state_t ST_IDLE    = 3'd0;
    localparam mem_state_t ST_ADDR    = 3'd1;
    localparam mem_state_t ST_RD_WAIT = 3'd2;
    localparam mem_state_t ST_WR_WAIT = 3'd3;
    localparam mem_state_t ST_DONE    = 3'd4;
    localparam mem_state_t ST_ERR     = 3'd5;

    localparam int MEM_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR enables and memory strobes for one
// read or write at a time, with wait states and an optional timeout abort.
module mem_access_ctrl
    import cpu_defs::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sclr,
    input  logic req,
    input  logic we,
    input  logic mem_ready,
    output logic busy,
    output logic done,
    output logic err,
    output logic mar_en,
    output logic mdr_en,
    output logic mdr_alu_n,
    output logic mem_rd,
    output logic mem_wr
);

    localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CW-1:0] CNT_TERM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic          TO_EN    = (TIMEOUT != 0);

    mem_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_q, we_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_q      <= we_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_q;
        if (sclr) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            we_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        we_next    = we;
                        state_next = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    cnt_next   = '0;
                    state_next = we_q ? ST_WR_WAIT : ST_RD_WAIT;
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    // Ready beats the terminal count when both land in the same cycle.
                    if (mem_ready) begin
                        state_next = ST_DONE;
                    end else if (TO_EN && (cnt_reg == CNT_TERM)) begin
                        state_next = ST_ERR;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                ST_ERR:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mar_en    = 1'b0;
        mdr_en    = 1'b0;
        mdr_alu_n = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (state_reg)
            ST_ADDR: begin
                busy   = 1'b1;
                mar_en = 1'b1;
                mdr_en = we_q;
            end
            ST_RD_WAIT: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                // Capture read data on the leaving edge; an abort must not load the MDR.
                mdr_en = mem_ready && !sclr;
            end
            ST_WR_WAIT: begin
                busy   = 1'b1;
                mem_wr = 1'b1;
            end
            ST_DONE: begin
                done      = 1'b1;
                mdr_alu_n = !we_q;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: per-cycle output expectations and per-transaction outcomes.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst, sclr, req, we, mem_ready;
    logic busy, done, err, mar_en, mdr_en, mdr_alu_n, mem_rd, mem_wr;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclr      (sclr),
        .req       (req),
        .we        (we),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mar_en    (mar_en),
        .mdr_en    (mdr_en),
        .mdr_alu_n (mdr_alu_n),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc_n  = 0;

    logic [7:0] exp_q[$];
    logic [1:0] txn_q[$];
    logic [7:0] mon_e;
    logic [1:0] mon_t;

    wire [7:0] act = {busy, done, err, mar_en, mdr_en, mdr_alu_n, mem_rd, mem_wr};

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [7:0] ov(input logic b, d, e, ma, md, al, rd, wr);
        return {b, d, e, ma, md, al, rd, wr};
    endfunction

    function automatic logic rb();
        return 1'($urandom & 1);
    endfunction

    // One clock cycle of stimulus plus the outputs the spec requires during it.
    task automatic cyc(input logic r, input logic s, input logic rq, input logic w,
                       input logic rdy, input logic [7:0] e);
        rst = r; sclr = s; req = rq; we = w; mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // d = wait cycles before mem_ready (ready in wait cycle d); ab = wait index of abort or -1.
    task automatic run_txn(input logic w, input int d, input int ab, input logic ab_rst);
        int   len;
        logic ok;
        logic rdy;
        ok  = (d < TO);
        len = ok ? d + 1 : TO;
        cyc(1'b1, 1'b0, 1'b1, w, rb(), 8'h00);
        cyc(1'b1, 1'b0, rb(), rb(), rb(), ov(1, 0, 0, 1, w, 0, 0, 0));
        for (int i = 0; i < len; i++) begin
            if (i == ab) begin
                if (ab_rst) begin
                    cyc(1'b0, 1'b0, rb(), rb(), 1'b0, 8'h00);
                    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
                end else begin
                    cyc(1'b1, 1'b1, rb(), rb(), 1'b0, ov(1, 0, 0, 0, 0, 0, !w, w));
                end
                return;
            end
            rdy = (i == d);
            cyc(1'b1, 1'b0, rb(), rb(), rdy, ov(1, 0, 0, 0, !w && rdy, 0, !w, w));
        end
        if (ok) begin
            txn_q.push_back(2'b10);
            cyc(1'b1, 1'b0, rb(), rb(), rb(), ov(0, 1, 0, 0, 0, !w, 0, 0));
        end else begin
            txn_q.push_back(2'b01);
            cyc(1'b1, 1'b0, rb(), rb(), rb(), ov(0, 0, 1, 0, 0, 0, 0, 0));
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            ntests++;
            if (act !== mon_e) begin
                nfail++;
                $display("FAIL outputs cycle=%0d busy/done/err/mar/mdr/alu/rd/wr actual=%b required=%b",
                         cyc_n, act, mon_e);
            end
        end
        if (done === 1'b1 || err === 1'b1) begin
            ntests++;
            if (txn_q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_end cycle=%0d actual done/err=%b%b required none", cyc_n, done, err);
            end else begin
                mon_t = txn_q.pop_front();
                if ({done, err} !== mon_t) begin
                    nfail++;
                    $display("FAIL txn_outcome cycle=%0d actual done/err=%b%b required=%b",
                             cyc_n, done, err, mon_t);
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, ab, len;
        logic w;
        rst = 1'b0; sclr = 1'b0; req = 1'b0; we = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, rb(), rb(), rb(), 8'h00);
        cyc(1'b0, 1'b0, rb(), rb(), rb(), 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        run_txn(1'b0, 0, -1, 1'b0);   // read, zero wait
        run_txn(1'b1, 3, -1, 1'b0);   // write, 3 waits
        run_txn(1'b0, 10, -1, 1'b0);  // read timeout
        run_txn(1'b0, 3, -1, 1'b0);   // ready at terminal count
        run_txn(1'b0, 9, 1, 1'b0);    // sclr in 2nd RD_WAIT
        run_txn(1'b1, 9, 1, 1'b1);    // reset mid WR_WAIT

        for (int n = 0; n < 300; n++) begin
            w   = rb();
            d   = $urandom_range(0, 6);
            len = (d < TO) ? d + 1 : TO;
            ab  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len - 1) : -1;
            run_txn(w, d, ab, rb());
            repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b0, 1'b0, rb(), rb(), 8'h00);
        end

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        ntests++;
        if (txn_q.size() != 0 || exp_q.size() != 0) begin
            nfail++;
            $display("FAIL drain actual pending txns=%0d cycles=%0d required 0 and 0",
                     txn_q.size(), exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
